and_unit_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one registered bitwise-AND unit among
//  N_REQ requesters. Sits between requester logic (ui_in/uio-derived in the
//  tt_um top) and the shared AND datapath. Accepts one operation at a time
//  and returns the result with the winner's ID over a valid/ready response.

---
 rtl/and_unit_arbiter.sv | 108 ++++++++++
 tb/tb_and_unit_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND unit among N_REQ requesters.
// Optional grant statistics counter enabled by defining STATS_EN.
module and_unit_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   op_a,
  input  logic [N_REQ*DATA_W-1:0]   op_b,
  output logic [N_REQ-1:0]          gnt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
`ifdef STATS_EN
  ,
  output logic [15:0]               grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   last_gnt;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              grant_fire;
  logic [DATA_W-1:0] a_q, b_q;
  int                idx;

  // Scan starts just after the previous winner so every requester gets a turn.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_gnt) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign grant_fire = (state == IDLE) && ena && found;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant_fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      last_gnt  <= ID_W'(N_REQ - 1);
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      gnt <= '0;
      if (grant_fire) begin
        gnt[winner] <= 1'b1;
        a_q         <= op_a[winner*DATA_W +: DATA_W];
        b_q         <= op_b[winner*DATA_W +: DATA_W];
        rsp_id      <= winner;
        last_gnt    <= winner;
      end
      if (state == EXEC) begin
        rsp_data  <= a_q & b_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_valid && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

`ifdef STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                    grant_cnt <= '0;
    else if (grant_fire && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed self-checking bench for and_unit_arbiter (N_REQ=4, DATA_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_and_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
`ifdef STATS_EN
  logic [15:0] grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

  and_unit_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; req = 4'b0; op_a = '0; op_b = '0; rsp_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_data",  32'(rsp_data), 32'h0);
    check("rst_id",    32'(rsp_id), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
`ifdef STATS_EN
    check("rst_cnt",   32'(grant_cnt), 32'h0);
`endif

    // Single request from requester 1
    rst = 1'b0; ena = 1'b1; req = 4'b0010; rsp_ready = 1'b1;
    op_a[15:8] = 8'hF0; op_b[15:8] = 8'h3C;
    step();
    check("t2_gnt",   32'(gnt), 32'h2);
    check("t2_busy",  32'(busy), 32'h1);
    check("t2_valid0", 32'(rsp_valid), 32'h0);
    req = 4'b0000; op_a[15:8] = 8'hFF; op_b[15:8] = 8'hFF;
    step();
    check("t2_valid", 32'(rsp_valid), 32'h1);
    check("t2_data",  32'(rsp_data), 32'h30);
    check("t2_id",    32'(rsp_id), 32'h1);
    check("t2_gnt_off", 32'(gnt), 32'h0);
    step();
    check("t2_drop",  32'(rsp_valid), 32'h0);
    check_idle("t2_end");

    // Reset again, then all requesters high: rotation 0,1,2,3,0
    rst = 1'b1;
    step(); step();
    check_idle("t3_rst");
    rst = 1'b0; req = 4'b1111; op_a = 32'h88442211; op_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_gnt",    32'(gnt), 32'h1 << (i % 4));
      check("t3_onehot", 32'($onehot(gnt)), 32'h1);
      step();
      check("t3_valid",  32'(rsp_valid), 32'h1);
      check("t3_id",     32'(rsp_id), 32'(i % 4));
      check("t3_data",   32'(rsp_data), 32'(exp_data[i % 4]));
      step();
      check_idle("t3_gap");
    end

    // Back-pressure: result holds, no new grant while stalled
    req = 4'b0100; op_a[23:16] = 8'hA5; op_b[23:16] = 8'h0F; rsp_ready = 1'b0;
    step();
    check("t4_gnt", 32'(gnt), 32'h4);
    req = 4'b1111;
    step();
    check("t4_valid", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_valid", 32'(rsp_valid), 32'h1);
      check("t4_hold_data",  32'(rsp_data), 32'h05);
      check("t4_hold_id",    32'(rsp_id), 32'h2);
      check("t4_hold_gnt",   32'(gnt), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    check("t4_drop", 32'(rsp_valid), 32'h0);
    req = 4'b0000;
    step();
    check_idle("t4_end");

    // ena low blocks new grants but not an in-flight operation
    ena = 1'b0; req = 4'b0001; op_a[7:0] = 8'hCC; op_b[7:0] = 8'hAA;
    step();
    check_idle("t5_blk0");
    step();
    check_idle("t5_blk1");
    ena = 1'b1;
    step();
    check("t5_gnt", 32'(gnt), 32'h1);
    ena = 1'b0;
    step();
    check("t5_valid", 32'(rsp_valid), 32'h1);
    check("t5_data",  32'(rsp_data), 32'h88);
    check("t5_id",    32'(rsp_id), 32'h0);
    step();
    check("t5_drop", 32'(rsp_valid), 32'h0);
    step();
    check_idle("t5_end");
    req = 4'b0000;

    // Reset during EXEC discards the operation
    ena = 1'b1; req = 4'b0010;
    step();
    check("t6_gnt", 32'(gnt), 32'h2);
    rst = 1'b1;
    step();
    check("t6_valid", 32'(rsp_valid), 32'h0);
    check("t6_data",  32'(rsp_data), 32'h0);
    check("t6_id",    32'(rsp_id), 32'h0);
    check_idle("t6_rst");
`ifdef STATS_EN
    check("t6_cnt_rst", 32'(grant_cnt), 32'h0);
`endif
    rst = 1'b0; req = 4'b0000;
    step();
    check("t6_valid_after", 32'(rsp_valid), 32'h0);

    // Three back-to-back grants to requester 0
    req = 4'b0001;
    repeat (7) step();
    check("t6_busy3", 32'(busy), 32'h1);
`ifdef STATS_EN
    check("t6_cnt3", 32'(grant_cnt), 32'h3);
`endif
    req = 4'b0000;
    repeat (4) step();
    check_idle("t6_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
